// File: rtl/ahb_cmd_master_if.sv
// rtl/ahb_cmd_master_if.sv - command/response streams and AHB-lite master bus bundle
interface ahb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  rsp_ready, HREADY, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWDATA, HWRITE, HTRANS, HSIZE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output rsp_ready, HREADY, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWDATA, HWRITE, HTRANS, HSIZE
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - command-to-AHB-lite single-transfer master with credit-limited response FIFO
module ahb_cmd_master #(
  parameter int RSP_DEPTH = 4
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_cmd_master_if.master bus
);
  localparam int         CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] rdata;
  } rsp_ent_t;

  logic          ap_valid;
  logic          ap_write;
  logic [31:0]   ap_addr;
  logic [31:0]   ap_wdata;
  logic [1:0]    ap_size;
  logic          dp_valid;
  logic          dp_write;
  logic [31:0]   hwdata_q;
  rsp_ent_t      fifo       [RSP_DEPTH];
  rsp_ent_t      fifo_shift [RSP_DEPTH];
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] wr_idx;
  logic [5:0]    inflight;
  logic          misaligned;
  logic          credit;
  logic          room;
  logic          cmd_ready_c;
  logic          cmd_fire;
  logic          issue;
  logic          ap_accept;
  logic          dp_done;
  logic          push;
  logic          pop;
  rsp_ent_t      push_ent;

  always_comb begin
    misaligned = (bus.cmd_size == 2'd3)
               || (bus.cmd_size == 2'd1 && bus.cmd_addr[0])
               || (bus.cmd_size == 2'd2 && bus.cmd_addr[1:0] != 2'b00);
    // every command in flight already owns a FIFO slot, so the FIFO can never overflow
    inflight = 6'(fifo_count) + 6'(ap_valid) + 6'(dp_valid);
    credit   = inflight < 6'(RSP_DEPTH);
    room     = 6'(fifo_count) < 6'(RSP_DEPTH);
    if (HRESET)
      cmd_ready_c = 1'b0;
    else if (misaligned)
      cmd_ready_c = !ap_valid && !dp_valid && room;
    else
      cmd_ready_c = credit && (!ap_valid || bus.HREADY);
    cmd_fire  = bus.cmd_valid && cmd_ready_c;
    issue     = cmd_fire && !misaligned;
    ap_accept = ap_valid && bus.HREADY;
    dp_done   = dp_valid && bus.HREADY;
    pop       = fifo[0].vld && bus.rsp_ready;
    push      = dp_done || (cmd_fire && misaligned);
    push_ent.vld   = 1'b1;
    push_ent.err   = !dp_done;
    push_ent.rdata = (dp_done && !dp_write) ? bus.HRDATA : 32'h0;
    wr_idx = fifo_count - CW'(pop);
    for (int i = 0; i < RSP_DEPTH - 1; i++)
      fifo_shift[i] = fifo[i + 1];
    fifo_shift[RSP_DEPTH - 1] = '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_valid   <= 1'b0;
      ap_write   <= 1'b0;
      ap_addr    <= 32'h0;
      ap_wdata   <= 32'h0;
      ap_size    <= 2'd0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      hwdata_q   <= 32'h0;
      fifo_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++)
        fifo[i] <= '0;
    end else begin
      if (issue) begin
        ap_valid <= 1'b1;
        ap_write <= bus.cmd_write;
        ap_addr  <= bus.cmd_addr;
        ap_size  <= bus.cmd_size;
        ap_wdata <= bus.cmd_wdata;
      end else if (ap_accept) begin
        ap_valid <= 1'b0;
      end
      if (ap_accept) begin
        dp_valid <= 1'b1;
        dp_write <= ap_write;
        hwdata_q <= ap_wdata;
      end else if (dp_done) begin
        dp_valid <= 1'b0;
      end
      // shift-down FIFO keeps the head in fifo[0]; a same-edge push lands behind the shifted tail
      if (pop)
        for (int i = 0; i < RSP_DEPTH; i++)
          fifo[i] <= fifo_shift[i];
      if (push)
        for (int i = 0; i < RSP_DEPTH; i++)
          if (wr_idx == CW'(i))
            fifo[i] <= push_ent;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.HTRANS    = ap_valid ? TR_NONSEQ : TR_IDLE;
  assign bus.HADDR     = ap_addr;
  assign bus.HWRITE    = ap_write;
  assign bus.HSIZE     = {1'b0, ap_size};
  assign bus.HWDATA    = hwdata_q;
  assign bus.rsp_valid = fifo[0].vld;
  assign bus.rsp_rdata = fifo[0].rdata;
  assign bus.rsp_err   = fifo[0].err;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb/tb_ahb_cmd_master.sv - randomized scoreboard bench for ahb_cmd_master
module tb_ahb_cmd_master;
  localparam int RSP_DEPTH = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } exp_bus_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  ahb_cmd_master_if bus();

  ahb_cmd_master #(.RSP_DEPTH(RSP_DEPTH)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  exp_rsp_t rsp_q[$];
  exp_bus_t bus_q[$];
  int ready_pct = 100;
  int rsp_pct = 100;
  int dp_wait_cfg = 0;
  int n_accept = 0;
  int n_pop = 0;
  int last_acc = 0;
  int last_lat = 0;
  int nseq = 0;
  int max_run = 0;
  logic sl_dp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h4) return 32'h12345678;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic misaligned_ref(input logic [1:0] size, input logic [31:0] addr);
    int unsigned bytes;
    if (size == 2'd3) return 1'b1;
    bytes = 1 << size;
    return (addr % bytes) != 0;
  endfunction

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
    exp_rsp_t er;
    exp_bus_t eb;
    int waited;
    logic mis;
    waited = 0;
    @(negedge HCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_wdata = wdata;
    #1;
    while (!bus.cmd_ready && waited < 300) begin
      @(negedge HCLK);
      #1;
      waited++;
    end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    mis = misaligned_ref(size, addr);
    er.err   = mis;
    er.rdata = (mis || wr) ? 32'h0 : slave_data(addr);
    er.acc   = cyc;
    rsp_q.push_back(er);
    if (!mis) begin
      eb.addr  = addr;
      eb.write = wr;
      eb.size  = {1'b0, size};
      eb.wdata = wdata;
      bus_q.push_back(eb);
    end
    n_accept++;
    last_acc = cyc;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || sl_dp) && n < 1000) begin
      @(negedge HCLK);
      n++;
    end
    repeat (2) @(negedge HCLK);
    chk("drain_rsp_q", rsp_q.size(), 0);
  endtask

  // response consumer
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge HCLK);
      bus.rsp_ready = ($urandom_range(99, 0) < rsp_pct);
    end
  end

  // response monitor: pops the scoreboard whenever a response is consumed
  initial begin
    exp_rsp_t er;
    forever begin
      @(negedge HCLK);
      #2;
      if (!HRESET && bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 1'b0);
        end else begin
          er = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, er.rdata);
          chk("rsp_err", bus.rsp_err, er.err);
          last_lat = cyc - er.acc;
          n_pop++;
        end
      end
    end
  end

  // AHB slave model and bus monitor
  initial begin
    exp_bus_t eb;
    logic        sl_write;
    logic [31:0] sl_addr;
    logic [31:0] sl_wdata;
    logic [31:0] sl_hw0;
    logic        sl_first;
    int          sl_wait;
    int          sl_run;
    logic        sl_hold;
    logic [37:0] sl_held;
    sl_write = 1'b0; sl_addr = '0; sl_wdata = '0; sl_hw0 = '0; sl_first = 1'b0;
    sl_wait = 0; sl_run = 0; sl_hold = 1'b0; sl_held = '0;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hBAD0BAD0;
    forever begin
      @(negedge HCLK);
      if (sl_dp && sl_wait > 0) begin
        bus.HREADY = 1'b0;
        sl_wait--;
      end else begin
        bus.HREADY = ($urandom_range(99, 0) < ready_pct);
      end
      bus.HRDATA = (sl_dp && !sl_write) ? slave_data(sl_addr) : 32'hBAD0BAD0;
      #3;
      if (HRESET) begin
        sl_dp = 1'b0;
        sl_hold = 1'b0;
        sl_run = 0;
      end else begin
        chk("htrans_legal", (bus.HTRANS == 2'b00 || bus.HTRANS == 2'b10), 1'b1);
        if (sl_hold)
          chk("ap_stable", {bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HTRANS}, sl_held);
        if (sl_dp) begin
          if (sl_write) chk("hwdata", bus.HWDATA, sl_wdata);
          if (sl_first) begin
            sl_hw0 = bus.HWDATA;
            sl_first = 1'b0;
          end else begin
            chk("hwdata_stable", bus.HWDATA, sl_hw0);
          end
        end
        if (bus.HTRANS == 2'b10) begin
          nseq++;
          sl_run++;
          if (sl_run > max_run) max_run = sl_run;
        end else begin
          sl_run = 0;
        end
        if (sl_dp && bus.HREADY) sl_dp = 1'b0;
        if (bus.HTRANS == 2'b10 && bus.HREADY) begin
          if (bus_q.size() == 0) begin
            chk("nonseq_unexpected", bus.HTRANS, 2'b00);
          end else begin
            eb = bus_q.pop_front();
            chk("haddr", bus.HADDR, eb.addr);
            chk("hwrite", bus.HWRITE, eb.write);
            chk("hsize", bus.HSIZE, eb.size);
            sl_dp    = 1'b1;
            sl_first = 1'b1;
            sl_addr  = eb.addr;
            sl_write = eb.write;
            sl_wdata = eb.wdata;
            sl_wait  = dp_wait_cfg;
          end
        end
        sl_hold = (bus.HTRANS == 2'b10 && !bus.HREADY);
        sl_held = {bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HTRANS};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nseq0;
    int acc0;
    int pop0;
    int acc_a;
    int n;
    logic fill_done;
    logic [31:0] a;
    logic [1:0] sz;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_size  = 2'd0;
    bus.cmd_wdata = 32'h0;
    fill_done = 1'b0;

    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_hwrite", bus.HWRITE, 1'b0);
    chk("rst_hsize", bus.HSIZE, 3'd0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    HRESET = 1'b0;

    nseq0 = nseq;
    send_cmd(1'b1, 32'h2000_0000, 2'd2, 32'hDEADBEEF);
    wait_drain();
    chk("wr_nonseq_cycles", nseq - nseq0, 1);
    chk("wr_rsp_latency", last_lat, 3);

    pop0 = n_pop;
    dp_wait_cfg = 3;
    send_cmd(1'b0, 32'h0000_0004, 2'd2, 32'h0);
    wait_drain();
    dp_wait_cfg = 0;
    chk("wait_rd_pops", n_pop - pop0, 1);

    nseq0 = nseq;
    max_run = 0;
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 32'h0000_1000 + 32'(i * 4), 2'd2, 32'h0);
    wait_drain();
    chk("b2b_nonseq_run", max_run, 4);
    chk("b2b_nonseq_cycles", nseq - nseq0, 4);

    rsp_pct = 0;
    acc0 = n_accept;
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++) send_cmd(1'b0, 32'h0000_0100 + 32'(i * 4), 2'd2, 32'h0);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        fill_done = 1'b1;
      end
    join_none
    repeat (20) @(negedge HCLK);
    #1;
    chk("fill_accepted", n_accept - acc0, 4);
    chk("fill_cmd_ready", bus.cmd_ready, 1'b0);
    chk("fill_rsp_valid", bus.rsp_valid, 1'b1);
    rsp_pct = 100;
    n = 0;
    while (!fill_done && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    chk("fill_done", fill_done, 1'b1);
    wait_drain();
    chk("fill_pops", n_pop - pop0, 6);

    nseq0 = nseq;
    send_cmd(1'b0, 32'h0000_0040, 2'd2, 32'h0);
    acc_a = last_acc;
    send_cmd(1'b1, 32'h0000_0003, 2'd1, 32'h0000_AAAA);
    wait_drain();
    chk("mis_wait_cycles", last_acc - acc_a, 3);
    chk("mis_nonseq_cycles", nseq - nseq0, 1);

    pop0 = n_pop;
    dp_wait_cfg = 20;
    send_cmd(1'b0, 32'h0000_0080, 2'd2, 32'h0);
    n = 0;
    while (!sl_dp && n < 20) begin
      @(negedge HCLK);
      bus.cmd_valid = 1'b0;
      n++;
    end
    repeat (2) @(negedge HCLK);
    HRESET = 1'b1;
    rsp_q.delete();
    bus_q.delete();
    @(negedge HCLK);
    #1;
    chk("mid_rst_htrans", bus.HTRANS, 2'b00);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("mid_rst_haddr", bus.HADDR, 32'h0);
    HRESET = 1'b0;
    dp_wait_cfg = 0;
    repeat (30) @(negedge HCLK);
    #1;
    chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("post_rst_pops", n_pop - pop0, 0);

    for (int k = 0; k < 240; k++) begin
      if (k % 40 == 0) begin
        ready_pct = $urandom_range(100, 40);
        rsp_pct   = $urandom_range(100, 30);
      end
      a  = $urandom;
      sz = 2'($urandom_range(3, 0));
      if (sz != 2'd3 && $urandom_range(3, 0) != 0) a[1:0] = 2'b00;
      send_cmd(1'($urandom_range(1, 0)), a, sz, $urandom);
      if ($urandom_range(7, 0) == 0) begin
        n = $urandom_range(3, 1);
        repeat (n) begin
          @(negedge HCLK);
          bus.cmd_valid = 1'b0;
        end
      end
    end
    ready_pct = 100;
    rsp_pct = 100;
    wait_drain();
    chk("final_bus_q", bus_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
